// File: rtl/scroll_pkg.sv
// Shared definitions for the background vertical-scroll scheduler.
package scroll_pkg;

  localparam int NT_ROWS   = 32;
  localparam int ROW_LINES = 16;
  localparam int PTR_W     = 9;

  localparam int ROW_SHIFT = $clog2(ROW_LINES);
  localparam int ROW_W     = $clog2(NT_ROWS);

  typedef logic [1:0] state_t;
  localparam state_t IDLE       = 2'd0;
  localparam state_t WAIT_FRAME = 2'd1;
  localparam state_t FETCH      = 2'd2;
  localparam state_t DONE       = 2'd3;

  // Flash byte address of an absolute background row: base + row * bytes-per-row, 24-bit wrap.
  function automatic logic [23:0] row_flash_addr(input logic [23:0] base,
                                                 input logic [15:0] row_num,
                                                 input logic [15:0] row_bytes);
    return base + 24'(32'(row_num) * 32'(row_bytes));
  endfunction

endpackage

// File: rtl/scroll_row_scheduler_frame_divider.sv
// Frame divider: counts qualified frames and emits a step when the programmed count is reached.
module scroll_frame_divider (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clear,
  input  logic       count_en,
  input  logic [7:0] cnt_max,
  output logic       step
);

  logic [7:0] frame_cnt_q;
  logic [7:0] frame_cnt_d;

  assign step = count_en && (frame_cnt_q >= cnt_max);

  // Next frame count: clear wins, a step restarts the count, otherwise count one more frame.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (clear) begin
      frame_cnt_d = '0;
    end else if (count_en) begin
      frame_cnt_d = step ? 8'd0 : frame_cnt_q + 8'd1;
    end
  end

  // Frame counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) frame_cnt_q <= '0;
    else       frame_cnt_q <= frame_cnt_d;
  end

endmodule

// File: rtl/scroll_row_scheduler.sv
// Scroll row scheduler: steps the scroll pointer per divided frame and requests one row fetch per 16 lines.
module scroll_row_scheduler
  import scroll_pkg::*;
#(
  parameter int ROW_BYTES    = 64,
  parameter int ROWS_PER_MAP = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        scrollEn,
  input  logic        scrollPause,
  input  logic [7:0]  scrollCntMax,
  input  logic [23:0] flashAddrStart,
  input  logic [7:0]  mapBackgroundMax,
  input  logic        createPlaneIntrEn,
  input  logic        vgaIntr,
  input  logic        fetch_ack,
  output logic        fetch_req,
  output logic [23:0] fetch_flashAddr,
  output logic [4:0]  fetch_rowIdx,
  output logic [8:0]  scrollPtrOut,
  output logic [7:0]  mapScrollPtr,
  output logic [7:0]  mapBackgroundCnt,
  output logic        scrollingFlag,
  output logic        frameOverrun,
  output logic        createPlaneIntr
);

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   scroll_ptr_q, scroll_ptr_d;
  logic [7:0]         map_scroll_ptr_q, map_scroll_ptr_d;
  logic [7:0]         map_bg_cnt_q, map_bg_cnt_d;
  logic               fetch_req_q, fetch_req_d;
  logic [23:0]        fetch_addr_q, fetch_addr_d;
  logic [ROW_W-1:0]   fetch_row_q, fetch_row_d;
  logic               overrun_q, overrun_d;
  logic               plane_intr_q, plane_intr_d;
  logic               scrolling_q, scrolling_d;

  logic               div_clear;
  logic               div_count;
  logic               div_step;
  logic [15:0]        abs_row;

  scroll_frame_divider u_divider (
    .clk      (clk),
    .rstn     (rstn),
    .clear    (div_clear),
    .count_en (div_count),
    .cnt_max  (scrollCntMax),
    .step     (div_step)
  );

  assign abs_row = 16'(map_bg_cnt_q) * 16'(ROWS_PER_MAP) + 16'(map_scroll_ptr_q);

  // Scheduler next-state: abort on disable, otherwise walk IDLE -> WAIT_FRAME <-> FETCH -> DONE.
  always_comb begin
    state_d          = state_q;
    scroll_ptr_d     = scroll_ptr_q;
    map_scroll_ptr_d = map_scroll_ptr_q;
    map_bg_cnt_d     = map_bg_cnt_q;
    fetch_req_d      = fetch_req_q;
    fetch_addr_d     = fetch_addr_q;
    fetch_row_d      = fetch_row_q;
    overrun_d        = overrun_q;
    plane_intr_d     = 1'b0;
    div_clear        = 1'b0;
    div_count        = 1'b0;

    if (!scrollEn) begin
      state_d     = IDLE;
      fetch_req_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          scroll_ptr_d     = '0;
          map_scroll_ptr_d = '0;
          map_bg_cnt_d     = '0;
          overrun_d        = 1'b0;
          div_clear        = 1'b1;
          state_d          = (mapBackgroundMax == 8'd0) ? DONE : WAIT_FRAME;
        end
        WAIT_FRAME: begin
          div_count = vgaIntr && !scrollPause;
          if (div_step) begin
            scroll_ptr_d = scroll_ptr_q + PTR_W'(1);
            if (scroll_ptr_d[ROW_SHIFT-1:0] == '0) begin
              state_d      = FETCH;
              fetch_req_d  = 1'b1;
              fetch_addr_d = row_flash_addr(flashAddrStart, abs_row, 16'(ROW_BYTES));
              fetch_row_d  = scroll_ptr_d[PTR_W-1:ROW_SHIFT] - ROW_W'(1);
            end
          end
        end
        FETCH: begin
          if (vgaIntr) overrun_d = 1'b1;
          if (fetch_ack) begin
            fetch_req_d = 1'b0;
            if (map_scroll_ptr_q == 8'(ROWS_PER_MAP - 1)) begin
              map_scroll_ptr_d = '0;
              map_bg_cnt_d     = map_bg_cnt_q + 8'd1;
              plane_intr_d     = createPlaneIntrEn;
              state_d          = (map_bg_cnt_d == mapBackgroundMax) ? DONE : WAIT_FRAME;
            end else begin
              map_scroll_ptr_d = map_scroll_ptr_q + 8'd1;
              state_d          = WAIT_FRAME;
            end
          end
        end
        DONE: begin
          fetch_req_d = 1'b0;
        end
        default: begin
          state_d     = IDLE;
          fetch_req_d = 1'b0;
        end
      endcase
    end

    scrolling_d = ((state_d == WAIT_FRAME) || (state_d == FETCH)) && !scrollPause;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q          <= IDLE;
      scroll_ptr_q     <= '0;
      map_scroll_ptr_q <= '0;
      map_bg_cnt_q     <= '0;
      fetch_req_q      <= 1'b0;
      fetch_addr_q     <= '0;
      fetch_row_q      <= '0;
      overrun_q        <= 1'b0;
      plane_intr_q     <= 1'b0;
      scrolling_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      scroll_ptr_q     <= scroll_ptr_d;
      map_scroll_ptr_q <= map_scroll_ptr_d;
      map_bg_cnt_q     <= map_bg_cnt_d;
      fetch_req_q      <= fetch_req_d;
      fetch_addr_q     <= fetch_addr_d;
      fetch_row_q      <= fetch_row_d;
      overrun_q        <= overrun_d;
      plane_intr_q     <= plane_intr_d;
      scrolling_q      <= scrolling_d;
    end
  end

  assign fetch_req        = fetch_req_q;
  assign fetch_flashAddr  = fetch_addr_q;
  assign fetch_rowIdx     = fetch_row_q;
  assign scrollPtrOut     = scroll_ptr_q;
  assign mapScrollPtr     = map_scroll_ptr_q;
  assign mapBackgroundCnt = map_bg_cnt_q;
  assign scrollingFlag    = scrolling_q;
  assign frameOverrun     = overrun_q;
  assign createPlaneIntr  = plane_intr_q;

endmodule

// File: tb/tb_scroll_row_scheduler.sv
// Self-checking bench for scroll_row_scheduler: directed scenarios plus randomized traffic against a row-count model.
module tb_scroll_row_scheduler;

  localparam int RB  = 64;
  localparam int RPM = 16;

  logic        clk = 1'b0;
  logic        rstn;
  logic        scrollEn;
  logic        scrollPause;
  logic [7:0]  scrollCntMax;
  logic [23:0] flashAddrStart;
  logic [7:0]  mapBackgroundMax;
  logic        createPlaneIntrEn;
  logic        vgaIntr;
  logic        fetch_ack;
  logic        fetch_req;
  logic [23:0] fetch_flashAddr;
  logic [4:0]  fetch_rowIdx;
  logic [8:0]  scrollPtrOut;
  logic [7:0]  mapScrollPtr;
  logic [7:0]  mapBackgroundCnt;
  logic        scrollingFlag;
  logic        frameOverrun;
  logic        createPlaneIntr;

  int errCount   = 0;
  int checkCount = 0;
  int planeCount = 0;

  // Reference model: progress is kept as total rows fetched; map position derives from it.
  int          m_ptr, m_rows, m_frames, m_row;
  bit          m_run, m_wait, m_fin, m_flag, m_ovr, m_intr;
  logic [23:0] m_addr;

  scroll_row_scheduler #(.ROW_BYTES(RB), .ROWS_PER_MAP(RPM)) dut (
    .clk               (clk),
    .rstn              (rstn),
    .scrollEn          (scrollEn),
    .scrollPause       (scrollPause),
    .scrollCntMax      (scrollCntMax),
    .flashAddrStart    (flashAddrStart),
    .mapBackgroundMax  (mapBackgroundMax),
    .createPlaneIntrEn (createPlaneIntrEn),
    .vgaIntr           (vgaIntr),
    .fetch_ack         (fetch_ack),
    .fetch_req         (fetch_req),
    .fetch_flashAddr   (fetch_flashAddr),
    .fetch_rowIdx      (fetch_rowIdx),
    .scrollPtrOut      (scrollPtrOut),
    .mapScrollPtr      (mapScrollPtr),
    .mapBackgroundCnt  (mapBackgroundCnt),
    .scrollingFlag     (scrollingFlag),
    .frameOverrun      (frameOverrun),
    .createPlaneIntr   (createPlaneIntr)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic modelStep();
    m_intr = 1'b0;
    if (!rstn) begin
      m_ptr = 0; m_rows = 0; m_frames = 0; m_row = 0; m_addr = '0;
      m_run = 0; m_wait = 0; m_fin = 0; m_ovr = 0;
    end else if (!scrollEn) begin
      m_run = 0; m_wait = 0; m_fin = 0;
    end else if (!m_run && !m_wait && !m_fin) begin
      m_ptr = 0; m_rows = 0; m_frames = 0; m_ovr = 0;
      if (mapBackgroundMax == 0) m_fin = 1;
      else m_run = 1;
    end else if (m_run) begin
      if (vgaIntr && !scrollPause) begin
        if (m_frames >= int'(scrollCntMax)) begin
          m_frames = 0;
          m_ptr = (m_ptr + 1) % 512;
          if (m_ptr % 16 == 0) begin
            m_run  = 0;
            m_wait = 1;
            m_addr = 24'(int'(flashAddrStart) + m_rows * RB);
            m_row  = (m_ptr / 16 + 31) % 32;
          end
        end else begin
          m_frames++;
        end
      end
    end else if (m_wait) begin
      if (vgaIntr) m_ovr = 1;
      if (fetch_ack) begin
        m_wait = 0;
        m_rows++;
        if (m_rows % RPM == 0) begin
          m_intr = createPlaneIntrEn;
          if ((m_rows / RPM) % 256 == int'(mapBackgroundMax)) m_fin = 1;
          else m_run = 1;
        end else begin
          m_run = 1;
        end
      end
    end
    m_flag = rstn && (m_run || m_wait) && !scrollPause;
  endtask

  task automatic compareAll();
    checkOutput("fetch_req", fetch_req, m_wait);
    checkOutput("fetch_flashAddr", fetch_flashAddr, m_addr);
    checkOutput("fetch_rowIdx", fetch_rowIdx, m_row);
    checkOutput("scrollPtrOut", scrollPtrOut, m_ptr);
    checkOutput("mapScrollPtr", mapScrollPtr, m_rows % RPM);
    checkOutput("mapBackgroundCnt", mapBackgroundCnt, (m_rows / RPM) % 256);
    checkOutput("scrollingFlag", scrollingFlag, m_flag);
    checkOutput("frameOverrun", frameOverrun, m_ovr);
    checkOutput("createPlaneIntr", createPlaneIntr, m_intr);
    planeCount += int'(createPlaneIntr);
  endtask

  // One clock: predict, let the DUT clock, compare on the falling edge, then drop pulses.
  task automatic runCycle();
    modelStep();
    @(posedge clk);
    @(negedge clk);
    compareAll();
    vgaIntr   = 1'b0;
    fetch_ack = 1'b0;
  endtask

  task automatic pulseVga();
    vgaIntr = 1'b1;
    runCycle();
    runCycle();
  endtask

  task automatic ackFetch();
    fetch_ack = 1'b1;
    runCycle();
  endtask

  task automatic waitForReq(input string tag);
    int budget = 0;
    while (!fetch_req && budget < 64) begin
      pulseVga();
      budget++;
    end
    checkOutput(tag, fetch_req, 1'b1);
  endtask

  task automatic applyStimulus(input int cycles, input int vgaPct, input int ackPct,
                               input int pausePct, input int abortPct);
    for (int n = 0; n < cycles; n++) begin
      if (!m_run && !m_wait && $urandom_range(9) == 0) begin
        scrollCntMax      = 8'($urandom_range(3));
        mapBackgroundMax  = 8'($urandom_range(3));
        flashAddrStart    = 24'($urandom);
        createPlaneIntrEn = 1'($urandom_range(1));
      end
      scrollEn    = ($urandom_range(99) >= abortPct);
      scrollPause = ($urandom_range(99) < pausePct);
      vgaIntr     = ($urandom_range(99) < vgaPct);
      fetch_ack   = ($urandom_range(99) < ackPct);
      runCycle();
    end
  endtask

  initial begin
    rstn = 1'b0; scrollEn = 1'b0; scrollPause = 1'b0; scrollCntMax = 8'd0;
    flashAddrStart = 24'h010000; mapBackgroundMax = 8'd2; createPlaneIntrEn = 1'b1;
    vgaIntr = 1'b0; fetch_ack = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) runCycle();
    checkOutput("reset_ptr", scrollPtrOut, 0);
    rstn = 1'b1;

    // One-line steps every frame, first row fetch on the 16th frame
    $display("[TB] step-per-frame and first fetch");
    scrollEn = 1'b1;
    runCycle();
    for (int i = 0; i < 16; i++) begin
      pulseVga();
      checkOutput("ptr_step", scrollPtrOut, i + 1);
    end
    checkOutput("first_req", fetch_req, 1'b1);
    checkOutput("first_row", fetch_rowIdx, 0);
    checkOutput("first_addr", fetch_flashAddr, 24'h010000);
    planeCount = 0;
    ackFetch();
    checkOutput("first_ack_msp", mapScrollPtr, 1);
    for (int r = 1; r < 17; r++) begin
      waitForReq("req_timeout");
      if (r == 16) checkOutput("row16_addr", fetch_flashAddr, 24'h010400);
      ackFetch();
    end
    checkOutput("plane_pulses_en", planeCount, 1);
    checkOutput("bg_after17", mapBackgroundCnt, 1);
    checkOutput("msp_after17", mapScrollPtr, 1);

    // Divide by three and pause
    $display("[TB] frame divider and pause");
    scrollEn = 1'b0; runCycle();
    scrollCntMax = 8'd2; scrollEn = 1'b1; runCycle();
    pulseVga(); checkOutput("div_p1", scrollPtrOut, 0);
    pulseVga(); checkOutput("div_p2", scrollPtrOut, 0);
    pulseVga(); checkOutput("div_p3", scrollPtrOut, 1);
    scrollPause = 1'b1; runCycle();
    checkOutput("pause_flag", scrollingFlag, 0);
    for (int i = 0; i < 5; i++) pulseVga();
    checkOutput("pause_ptr", scrollPtrOut, 1);
    scrollPause = 1'b0;
    pulseVga(); pulseVga(); pulseVga();
    checkOutput("resume_ptr", scrollPtrOut, 2);

    // Single map background, no spawn pulse, then DONE
    $display("[TB] single map to DONE");
    scrollEn = 1'b0; runCycle();
    scrollCntMax = 8'd0; mapBackgroundMax = 8'd1; createPlaneIntrEn = 1'b0;
    scrollEn = 1'b1; runCycle();
    planeCount = 0;
    for (int r = 0; r < 16; r++) begin
      waitForReq("req_timeout");
      ackFetch();
    end
    checkOutput("done_flag", scrollingFlag, 0);
    checkOutput("done_ptr", scrollPtrOut, 256);
    checkOutput("plane_pulses_dis", planeCount, 0);
    pulseVga(); pulseVga(); pulseVga();
    checkOutput("done_ptr_hold", scrollPtrOut, 256);
    checkOutput("done_req", fetch_req, 0);
    scrollEn = 1'b0; runCycle();

    // Held ack across two frames sets the overrun flag
    $display("[TB] overrun while fetch pending");
    mapBackgroundMax = 8'd3; createPlaneIntrEn = 1'b1;
    scrollEn = 1'b1; runCycle();
    waitForReq("req_timeout");
    pulseVga(); pulseVga();
    checkOutput("ovr_flag", frameOverrun, 1);
    checkOutput("ovr_ptr", scrollPtrOut, 16);
    checkOutput("ovr_req", fetch_req, 1);
    ackFetch();

    // Abort mid-fetch, stray ack, re-enable, full pointer wrap
    $display("[TB] abort, re-enable and wrap");
    waitForReq("req_timeout");
    scrollEn = 1'b0; runCycle();
    checkOutput("abort_req", fetch_req, 0);
    ackFetch();
    checkOutput("abort_msp", mapScrollPtr, 1);
    mapBackgroundMax = 8'd255; flashAddrStart = 24'h123400;
    scrollEn = 1'b1; runCycle();
    checkOutput("reen_ptr", scrollPtrOut, 0);
    checkOutput("reen_msp", mapScrollPtr, 0);
    checkOutput("reen_ovr", frameOverrun, 0);
    for (int i = 0; i < 512; i++) begin
      if (fetch_req) ackFetch();
      pulseVga();
    end
    checkOutput("wrap_ptr", scrollPtrOut, 0);
    checkOutput("wrap_req", fetch_req, 1);
    checkOutput("wrap_row", fetch_rowIdx, 31);
    checkOutput("wrap_addr", fetch_flashAddr, 24'h123BC0);

    // Reset while a fetch is pending
    rstn = 1'b0; runCycle();
    checkOutput("rst_req", fetch_req, 0);
    rstn = 1'b1;

    // Randomized traffic
    $display("[TB] randomized traffic");
    applyStimulus(2000, 60, 30, 10, 0);
    applyStimulus(2000, 40, 20, 20, 2);
    applyStimulus(2000, 90, 5, 0, 0);
    applyStimulus(2000, 50, 50, 5, 1);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/scroll_row_scheduler.md
# scroll_row_scheduler

Frame-synchronous scheduler for background vertical scrolling. It consumes the one-cycle VGA end-of-window pulse and divides it down by the CPU-programmed frame count. It advances a 9-bit nametable scroll pointer and, at every 16-line row boundary, issues one row-fetch request (flash address plus nametable row) to the SPI-flash-to-nametable fetcher over a req/ack handshake. It also tracks map progress and raises the enemy-spawn pulse to the CPU.

## Interface
Parameters:
- ROW_BYTES, 64: flash bytes per background row.
- ROWS_PER_MAP, 16: rows per map background; must be a power of two, ≤256.

Ports (clock and reset first):
- clk  in  1  single clock (100 MHz domain).
- rstn  in  1  reset, synchronous, active-low.
- scrollEn  in  1  level; 0 forces IDLE.
- scrollPause  in  1  level; freezes frame counting.
- scrollCntMax  in  8  frames per one-line scroll step, minus 1.
- flashAddrStart  in  24  flash byte address of map 0, row 0.
- mapBackgroundMax  in  8  number of map backgrounds to scroll through.
- createPlaneIntrEn  in  1  enables createPlaneIntr.
- vgaIntr  in  1  one-cycle end-of-window pulse.
- fetch_ack  in  1  one-cycle pulse: requested row written to nametable.
- fetch_req  out  1  row fetch request, held until ack.
- fetch_flashAddr  out  24  flash address of requested row; stable while fetch_req=1.
- fetch_rowIdx  out  5  nametable row (0..31) to overwrite; stable while fetch_req=1.
- scrollPtrOut  out  9  current scroll line, 0..511, wraps.
- mapScrollPtr  out  8  rows completed in current map, 0..ROWS_PER_MAP-1.
- mapBackgroundCnt  out  8  map backgrounds completed.
- scrollingFlag  out  1  scrolling active.
- frameOverrun  out  1  sticky: a vgaIntr arrived while FETCH was pending.
- createPlaneIntr  out  1  one-cycle spawn pulse.

## Operation
- Reset: all outputs 0, frame counter 0, state IDLE.
- IDLE:
  - On scrollEn=1, clear scrollPtrOut, mapScrollPtr, mapBackgroundCnt, frame counter and frameOverrun.
  - Go to DONE if mapBackgroundMax=0; otherwise go to WAIT_FRAME.
- WAIT_FRAME:
  - On vgaIntr with scrollPause=0, evaluate the frame counter.
  - If frameCnt ≥ scrollCntMax: clear frameCnt, scrollPtrOut += 1 (mod 512).
  - Otherwise frameCnt += 1.
  - If the incremented pointer has bits [3:0]=0, go to FETCH.
  - On FETCH entry, register the following, then assert fetch_req:
    - fetch_flashAddr = flashAddrStart + (mapBackgroundCnt·ROWS_PER_MAP + mapScrollPtr)·ROW_BYTES, truncated to 24 bits.
    - fetch_rowIdx = newPtr[8:4] − 1 (mod 32), the row just vacated.
- FETCH:
  - Hold req, address and row stable.
  - A vgaIntr in this state is dropped, not counted, and sets frameOverrun.
  - On fetch_ack, drop fetch_req and mapScrollPtr += 1.
  - If the completed row was ROWS_PER_MAP−1:
    - mapScrollPtr ← 0, mapBackgroundCnt += 1.
    - Pulse createPlaneIntr if createPlaneIntrEn=1.
    - Go to DONE if the new mapBackgroundCnt = mapBackgroundMax.
  - Otherwise return to WAIT_FRAME.
- DONE: all counters hold, fetch_req=0; exit to IDLE only when scrollEn=0.
- scrollingFlag = 1 in WAIT_FRAME or FETCH with scrollPause=0; otherwise 0.
- Abort: scrollEn=0 in any state → IDLE next cycle.
  - fetch_req drops that cycle.
  - Counters hold their values until the next enable.
- fetch_ack outside FETCH is ignored.
- scrollPause=1 during FETCH does not block the ack.
- Config inputs are sampled live; the CPU changes them only while in IDLE or DONE.

## Timing
- All outputs are registered.
- vgaIntr → scrollPtrOut update: 1 cycle.
- Boundary step: fetch_req asserts on the same edge as the pointer update, with address and row valid that edge.
- fetch_ack → fetch_req low, and mapScrollPtr/mapBackgroundCnt/createPlaneIntr updated: 1 cycle.
- Earliest new request after an ack: the next qualifying vgaIntr plus 1 cycle.
- vgaIntr and fetch_ack in the same cycle while in FETCH: the ack is processed, the frame is dropped, and frameOverrun is set.
- A reset mid-FETCH clears fetch_req on that edge.

## Structure
- Shared package scroll_pkg holds:
  - state enum {IDLE, WAIT_FRAME, FETCH, DONE};
  - NT_ROWS=32, ROW_LINES=16, PTR_W=9.
- Sub-module scroll_frame_divider: 8-bit frame counter with pause and clear; emits a one-cycle step pulse.
- Address computation is one multiply-add, registered on FETCH entry.

## Test plan
- scrollCntMax=0, 16 vgaIntr pulses → ptr 1..16; one fetch_req on the 16th with fetch_rowIdx=0, flashAddr=flashAddrStart.
- scrollCntMax=2 → pointer steps on every third vgaIntr; scrollPause=1 for 5 pulses → no change, scrollingFlag=0.
- ROW_BYTES=64, flashAddrStart=0x010000, ack 17 rows → 17th address 0x010400, mapBackgroundCnt=1; createPlaneIntr pulses once after row 15's ack (en=1), none with en=0.
- mapBackgroundMax=1 → after the 16th ack the block enters DONE, scrollingFlag=0, further vgaIntr ignored; scrollEn=0 → IDLE.
- Hold fetch_ack off across 2 vgaIntr → req, address and row stable; frameOverrun=1; pointer unchanged until ack.
- scrollEn dropped mid-FETCH → fetch_req=0 next cycle; a later ack is ignored; re-enable clears all counters; a 512-line run wraps the pointer to 0.
